traffic_ctrl_rr: RTL



---
 rtl/traffic_pkg.sv | 29 ++
 rtl/traffic_ctrl_rr_rr_pick.sv | 40 ++++
 rtl/traffic_ctrl_rr.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/traffic_pkg.sv
// -----------------------------------------------------------------------------
// traffic_pkg
// Shared types and constants for the round-robin traffic phase controller.
//   state_t      : controller phase (GREEN / YELLOW / ALL_RED), 2-bit encoding;
//                  the fourth encoding is illegal and recovers to reset values.
//   dir_w()      : width of an approach index for a given approach count.
//   DEF_*        : default timing / geometry constants.
// -----------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    GREEN   = 2'b00,
    YELLOW  = 2'b01,
    ALL_RED = 2'b10
  } state_t;

  localparam int DEF_NUM_DIR      = 4;
  localparam int DEF_SENS_PER_DIR = 2;
  localparam int DEF_GREEN_MIN    = 8;
  localparam int DEF_GREEN_MAX    = 32;
  localparam int DEF_YELLOW_CYC   = 3;
  localparam int DEF_ALLRED_CYC   = 2;

  // An approach index needs at least one bit even for two approaches.
  function automatic int dir_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/traffic_ctrl_rr_rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin search: returns the first set bit of req found
// when scanning start, start+1, ... modulo NUM_DIR.
//   req   in  NUM_DIR          request vector
//   start in  $clog2(NUM_DIR)  first index examined
//   found out 1                some request bit is set
//   idx   out $clog2(NUM_DIR)  index of the first requester (0 when none)
// -----------------------------------------------------------------------------
module rr_pick
  import traffic_pkg::*;
#(
  parameter int NUM_DIR = DEF_NUM_DIR
) (
  input  logic [NUM_DIR-1:0]         req,
  input  logic [$clog2(NUM_DIR)-1:0] start,
  output logic                       found,
  output logic [$clog2(NUM_DIR)-1:0] idx
);

  localparam int DW = $clog2(NUM_DIR);

  logic [DW-1:0] pos;

  // Walk the ring once from start; the first hit wins and later hits are
  // ignored because found is already set.
  always_comb begin
    found = 1'b0;
    idx   = '0;
    pos   = '0;
    for (int k = 0; k < NUM_DIR; k++) begin
      pos = DW'((32'(start) + 32'(k)) % NUM_DIR);
      if (!found && req[pos]) begin
        found = 1'b1;
        idx   = pos;
      end
    end
  end

endmodule

// File: rtl/traffic_ctrl_rr.sv
// -----------------------------------------------------------------------------
// traffic_ctrl_rr
// N-approach traffic-light phase controller with min/max green, yellow and
// all-red clearance, granting sensor demand round-robin after the current
// approach. All outputs are registered.
//   clk          in  1                      system clock
//   rst_n        in  1                      async active-low reset
//   sensors      in  NUM_DIR*SENS_PER_DIR   demand, approach d owns
//                                           bits [d*SENS_PER_DIR +: SENS_PER_DIR]
//   preempt_vld  in  1                      (TRAFFIC_PREEMPT_EN only)
//   preempt_dir  in  $clog2(NUM_DIR)        (TRAFFIC_PREEMPT_EN only)
//   green        out NUM_DIR                one-hot green lamp or zero
//   yellow       out NUM_DIR                one-hot yellow lamp or zero
//   all_red      out 1                      all-red clearance active
//   cur_dir      out $clog2(NUM_DIR)        approach owning green/yellow
//   phase_start  out 1                      first green cycle of new approach
// Optional feature macro: TRAFFIC_PREEMPT_EN (emergency preemption).
// -----------------------------------------------------------------------------
module traffic_ctrl_rr
  import traffic_pkg::*;
#(
  parameter int NUM_DIR      = DEF_NUM_DIR,
  parameter int SENS_PER_DIR = DEF_SENS_PER_DIR,
  parameter int GREEN_MIN    = DEF_GREEN_MIN,
  parameter int GREEN_MAX    = DEF_GREEN_MAX,
  parameter int YELLOW_CYC   = DEF_YELLOW_CYC,
  parameter int ALLRED_CYC   = DEF_ALLRED_CYC
) (
  input  logic                            clk,
  input  logic                            rst_n,
  input  logic [NUM_DIR*SENS_PER_DIR-1:0] sensors,
`ifdef TRAFFIC_PREEMPT_EN
  input  logic                            preempt_vld,
  input  logic [$clog2(NUM_DIR)-1:0]      preempt_dir,
`endif
  output logic [NUM_DIR-1:0]              green,
  output logic [NUM_DIR-1:0]              yellow,
  output logic                            all_red,
  output logic [$clog2(NUM_DIR)-1:0]      cur_dir,
  output logic                            phase_start
);

  localparam int DW = $clog2(NUM_DIR);
  localparam int TW = $clog2(GREEN_MAX + 1);

  state_t            state_q, state_d;
  logic [DW-1:0]     nxt_dir_q, nxt_dir_d, cur_dir_d;
  logic [TW-1:0]     timer_q, timer_d, timer_inc;
  logic [31:0]       t_ext;
  logic [NUM_DIR-1:0] req, req_other;
  logic [DW-1:0]     search_start;
  logic              cand_found;
  logic [DW-1:0]     cand_idx;
  logic              pre_act;
  logic [DW-1:0]     pre_dir;
  logic              leave_green;
  logic [NUM_DIR-1:0] green_d, yellow_d;
  logic              all_red_d, phase_start_d;

  // Per-approach demand; the current approach is masked out so the ring
  // search starting just after it can only land on another approach.
  always_comb begin
    req = '0;
    for (int d = 0; d < NUM_DIR; d++) begin
      req[d] = |sensors[d*SENS_PER_DIR +: SENS_PER_DIR];
    end
    req_other    = req & ~(NUM_DIR'(1) << cur_dir);
    search_start = (32'(cur_dir) + 32'd1 == 32'(NUM_DIR)) ? '0 : cur_dir + 1'b1;
  end

  rr_pick #(
    .NUM_DIR (NUM_DIR)
  ) u_pick (
    .req   (req_other),
    .start (search_start),
    .found (cand_found),
    .idx   (cand_idx)
  );

  // Preemption collapses to a constant-off request in the default build so
  // the phase logic below is identical in both configurations.
`ifdef TRAFFIC_PREEMPT_EN
  assign pre_act = preempt_vld && (32'(preempt_dir) < 32'(NUM_DIR));
  assign pre_dir = preempt_dir;
`else
  assign pre_act = 1'b0;
  assign pre_dir = '0;
`endif

  assign t_ext     = 32'(timer_q);
  assign timer_inc = (t_ext >= 32'(GREEN_MAX)) ? timer_q : timer_q + 1'b1;

  // Green is released either when the own approach went idle after the
  // minimum, or unconditionally at the maximum, but only if someone waits.
  assign leave_green = cand_found &&
                       ((!req[cur_dir] && t_ext >= 32'(GREEN_MIN - 1)) ||
                        t_ext >= 32'(GREEN_MAX - 1));

  // Next-state logic. The registered outputs are derived from the next state
  // so lamps change on the same edge as the state itself.
  always_comb begin
    state_d   = state_q;
    cur_dir_d = cur_dir;
    nxt_dir_d = nxt_dir_q;
    timer_d   = timer_inc;

    case (state_q)
      GREEN: begin
        if (pre_act) begin
          if (pre_dir != cur_dir) begin
            state_d   = YELLOW;
            nxt_dir_d = pre_dir;
          end
        end else if (leave_green) begin
          state_d   = YELLOW;
          nxt_dir_d = cand_idx;
        end
      end
      YELLOW: begin
        if (pre_act) nxt_dir_d = pre_dir;
        if (t_ext >= 32'(YELLOW_CYC - 1)) begin
          if (ALLRED_CYC == 0) begin
            state_d   = GREEN;
            cur_dir_d = nxt_dir_d;
          end else begin
            state_d = ALL_RED;
          end
        end
      end
      ALL_RED: begin
        if (pre_act) nxt_dir_d = pre_dir;
        if ((ALLRED_CYC == 0) || t_ext >= 32'(ALLRED_CYC - 1)) begin
          state_d   = GREEN;
          cur_dir_d = nxt_dir_d;
        end
      end
      default: begin
        state_d   = GREEN;
        cur_dir_d = '0;
        nxt_dir_d = '0;
      end
    endcase

    if (state_d != state_q) timer_d = '0;

    green_d       = (state_d == GREEN)  ? (NUM_DIR'(1) << cur_dir_d) : '0;
    yellow_d      = (state_d == YELLOW) ? (NUM_DIR'(1) << cur_dir_d) : '0;
    all_red_d     = (state_d == ALL_RED);
    phase_start_d = (state_d == GREEN) &&
                    ((state_q == YELLOW) || (state_q == ALL_RED));
  end

  // State, timer and lamp registers all move together on the rising edge;
  // reset parks the controller on approach 0 green.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= GREEN;
      cur_dir     <= '0;
      nxt_dir_q   <= '0;
      timer_q     <= '0;
      green       <= NUM_DIR'(1);
      yellow      <= '0;
      all_red     <= 1'b0;
      phase_start <= 1'b0;
    end else begin
      state_q     <= state_d;
      cur_dir     <= cur_dir_d;
      nxt_dir_q   <= nxt_dir_d;
      timer_q     <= timer_d;
      green       <= green_d;
      yellow      <= yellow_d;
      all_red     <= all_red_d;
      phase_start <= phase_start_d;
    end
  end

endmodule
